fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BOOT_PC, default 32'h00001000, SHALL be the PC loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 8 (power of two), SHALL be the number of branch target buffer entries.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 stall_core_i  in  1  SHALL mean the pipeline cannot accept an instruction this cycle.
REQ-006 redirect_i  in  1 / redirect_pc_i  in  32  SHALL mean a mispredict or exception redirect to redirect_pc_i.
REQ-007 imem_req_o  out  1 / imem_addr_o  out  32  SHALL be the level-held instruction memory request and word address.
REQ-008 imem_valid_i  in  1 / imem_data_i  in  32 / imem_fault_i  in  1  SHALL be the single-cycle memory response, its data and its access-fault flag.
REQ-009 bp_upd_i  in  1 / bp_upd_pc_i  in  32 / bp_upd_target_i  in  32 / bp_upd_taken_i  in  1  SHALL be the resolved-branch update from execute.
REQ-010 fetch_instr_o, fetch_pc_o, fetch_pred_pc_o  out  32  SHALL be the fetched instruction, its PC and its predicted next PC.
REQ-011 fetch_prediction_o, fetch_taken_o  out  1  SHALL flag a BTB hit and a predicted-taken branch.
REQ-012 fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o  out  1  SHALL flag fetch exceptions.
REQ-013 stall_fetch_o  out  1  SHALL be high whenever the fetch_* outputs do not hold a valid instruction.

Function
REQ-014 The FSM SHALL have the states FETCH, VALID and DROP.
REQ-015 In FETCH with pc[1:0]==0: imem_req_o=1 and imem_addr_o=pc, held until imem_valid_i; at most one request SHALL be outstanding.
REQ-016 In FETCH with pc[1:0]!=0: no request; next cycle -> VALID with instr=32'h00000013 and misaligned_exc=1.
REQ-017 On imem_valid_i in FETCH -> VALID; outputs registered; imem_fault_i=1 SHALL give instr=32'h00000013 and fault_exc=1.
REQ-018 In VALID: stall_fetch_o=0 and all outputs held stable while stall_core_i=1.
REQ-019 Consume (VALID & !stall_core_i) SHALL set pc<=fetch_pred_pc_o and go to FETCH; the new request appears the following cycle (minimum 2 cycles between consumed instructions).
REQ-020 Prediction at response: BTB index pc[log2(BTB_ENTRIES)+1:2], tag pc[31:log2+2]; hit -> prediction=1, taken=counter[1], pred_pc=taken?target:pc+4; miss -> prediction=0, taken=0, pred_pc=pc+4 (32-bit wrap).
REQ-021 BTB update: 2-bit saturating counter (0..3); on tag hit, inc if taken, else dec; on miss and taken, allocate with target and counter=2'b10; no allocation on not-taken miss.
REQ-022 An update and a lookup on the same index in the same cycle: the lookup SHALL see the pre-update value.
REQ-023 redirect_i SHALL take priority over all events: pc<=redirect_pc_i, outputs invalidated (stall_fetch_o=1 next cycle); request outstanding and no response this cycle -> DROP, else -> FETCH.
REQ-024 In DROP: imem_req_o=0; the stale response SHALL be discarded, then -> FETCH; a further redirect in DROP updates pc only.
REQ-025 Redirect coincident with consume or a response: redirect wins; response discarded.

Reset
REQ-026 On rst_i: state=FETCH, pc=BOOT_PC, all data outputs 0, stall_fetch_o=1, imem_req_o=0 that cycle, all BTB valid bits cleared; reset mid-request SHALL abandon it without entering DROP.

Structure
REQ-027 State encoding, NOP constant 32'h00000013 and BOOT_PC default SHALL live in the shared core package.
REQ-028 The BTB SHALL be a sub-module named branch_target_buffer (lookup port, update port).

Verification
REQ-029 Reset, memory returns 32'hDEADBEEF after 1 cycle -> fetch_pc_o=32'h1000, instr=32'hDEADBEEF, pred_pc=32'h1004, stall_fetch_o=0.
REQ-030 Redirect to 32'h2002 -> no imem_req_o; next cycle misaligned_exc=1, instr=32'h00000013.
REQ-031 Redirect while request outstanding, stale response 2 cycles later -> response discarded, new request at redirect_pc_i.
REQ-032 Update pc 32'h1000 taken target 32'h3000, then refetch 32'h1000 -> prediction=1, taken=1, pred_pc=32'h3000; three not-taken updates -> taken=0, counter 0.
REQ-033 stall_core_i high 5 cycles in VALID -> outputs constant, no new request; release -> next request at pred_pc.
REQ-034 imem_fault_i=1 with response -> fault_exc=1, instr=32'h00000013.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, constants, output bundle
// and the branch-predictor counter update rule.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] BOOT_PC_DEFAULT = 32'h0000_1000;
  localparam logic [XLEN-1:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_BYTES     = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_pc;
    logic            prediction;
    logic            taken;
    logic            misaligned;
    logic            fault;
  } fetch_out_t;

  // 2-bit saturating taken/not-taken counter
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'd3) nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'd0) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_valid_i;
  logic [XLEN-1:0] imem_data_i;
  logic            imem_fault_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_valid_i,
    input  imem_data_i,
    input  imem_fault_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_valid_i,
    output imem_data_i,
    output imem_fault_i
  );

endinterface

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, registered
// update port, so a same-cycle lookup always sees the pre-update entry.
module branch_target_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_hit_c,
  output logic            o_lookup_taken_c,
  output logic [XLEN-1:0] o_lookup_target_c,
  input  logic            i_upd,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_unused_pc_bits;

  assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag = i_lookup_pc[XLEN-1:IDX_W+2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_unused_pc_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign o_lookup_hit_c    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_lookup_taken_c  = o_lookup_hit_c && r_ctr[w_lk_idx][1];
  assign o_lookup_target_c = r_target[w_lk_idx];

  // Train on hit; allocate only taken misses, starting weakly taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_upd) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= sat_ctr_next(r_ctr[w_up_idx], i_upd_taken);
      end else if (i_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, BTB-based next-PC
// prediction, redirect handling with stale-response drop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_PC     = BOOT_PC_DEFAULT,
  parameter int unsigned     BTB_ENTRIES = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_core_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_unit_if.master    imem,
  input  logic            bp_upd_i,
  input  logic [XLEN-1:0] bp_upd_pc_i,
  input  logic [XLEN-1:0] bp_upd_target_i,
  input  logic            bp_upd_taken_i,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [XLEN-1:0] fetch_pred_pc_o,
  output logic            fetch_prediction_o,
  output logic            fetch_taken_o,
  output logic            fetch_misaligned_instr_exc_o,
  output logic            fetch_instr_fault_exc_o,
  output logic            stall_fetch_o
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  fetch_out_t      r_out;
  logic            r_stall;

  logic            w_aligned;
  logic            w_pending;
  logic [XLEN-1:0] w_seq_pc;
  logic            w_btb_hit;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_pred_pc;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign w_pending = (r_state == FETCH) && w_aligned;
  assign w_seq_pc  = r_pc + INSTR_BYTES;
  assign w_pred_pc = w_btb_taken ? w_btb_target : w_seq_pc;

  assign imem.imem_req_o  = w_pending && !rst_i;
  assign imem.imem_addr_o = r_pc;

  branch_target_buffer #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .i_clk            (clk_i),
    .i_rst            (rst_i),
    .i_lookup_pc      (r_pc),
    .o_lookup_hit_c   (w_btb_hit),
    .o_lookup_taken_c (w_btb_taken),
    .o_lookup_target_c(w_btb_target),
    .i_upd            (bp_upd_i),
    .i_upd_pc         (bp_upd_pc_i),
    .i_upd_target     (bp_upd_target_i),
    .i_upd_taken      (bp_upd_taken_i)
  );

  // Redirect outranks everything; an unanswered request must be drained in DROP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FETCH;
      r_pc    <= BOOT_PC;
      r_out   <= '0;
      r_stall <= 1'b1;
    end else if (redirect_i) begin
      r_pc    <= redirect_pc_i;
      r_stall <= 1'b1;
      r_state <= ((w_pending || r_state == DROP) && !imem.imem_valid_i) ? DROP : FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (!w_aligned) begin
            r_out <= '{instr: NOP_INSTR, pc: r_pc, pred_pc: w_seq_pc,
                       prediction: 1'b0, taken: 1'b0, misaligned: 1'b1, fault: 1'b0};
            r_state <= VALID;
            r_stall <= 1'b0;
          end else if (imem.imem_valid_i) begin
            r_out <= '{instr: imem.imem_fault_i ? NOP_INSTR : imem.imem_data_i,
                       pc: r_pc, pred_pc: w_pred_pc,
                       prediction: w_btb_hit, taken: w_btb_taken,
                       misaligned: 1'b0, fault: imem.imem_fault_i};
            r_state <= VALID;
            r_stall <= 1'b0;
          end
        end
        VALID: begin
          if (!stall_core_i) begin
            r_pc    <= r_out.pred_pc;
            r_state <= FETCH;
            r_stall <= 1'b1;
          end
        end
        DROP: begin
          if (imem.imem_valid_i) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign fetch_instr_o                = r_out.instr;
  assign fetch_pc_o                   = r_out.pc;
  assign fetch_pred_pc_o              = r_out.pred_pc;
  assign fetch_prediction_o           = r_out.prediction;
  assign fetch_taken_o                = r_out.taken;
  assign fetch_misaligned_instr_exc_o = r_out.misaligned;
  assign fetch_instr_fault_exc_o      = r_out.fault;
  assign stall_fetch_o                = r_stall;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side memory, transaction-level reference model,
// per-cycle compare plus directed literal checks and a randomized phase.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam int NENT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, stall_core_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        bp_upd_i, bp_upd_taken_i;
  logic [31:0] bp_upd_pc_i, bp_upd_target_i;
  logic [31:0] fetch_instr_o, fetch_pc_o, fetch_pred_pc_o;
  logic        fetch_prediction_o, fetch_taken_o;
  logic        fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o, stall_fetch_o;

  fetch_unit_if u_if ();

  fetch_unit #(.BOOT_PC(BOOT), .BTB_ENTRIES(NENT)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_core_i(stall_core_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem(u_if.master),
    .bp_upd_i(bp_upd_i), .bp_upd_pc_i(bp_upd_pc_i),
    .bp_upd_target_i(bp_upd_target_i), .bp_upd_taken_i(bp_upd_taken_i),
    .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .fetch_pred_pc_o(fetch_pred_pc_o), .fetch_prediction_o(fetch_prediction_o),
    .fetch_taken_o(fetch_taken_o),
    .fetch_misaligned_instr_exc_o(fetch_misaligned_instr_exc_o),
    .fetch_instr_fault_exc_o(fetch_instr_fault_exc_o),
    .stall_fetch_o(stall_fetch_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage currently presents, plus whether it owes a stale response
  logic [31:0] m_pc;
  bit          m_shown, m_stale;
  logic [31:0] e_instr, e_pc, e_pred;
  bit          e_hit, e_taken, e_mis, e_fault;
  bit          b_valid [NENT];
  logic [31:0] b_tag   [NENT];
  logic [31:0] b_tgt   [NENT];
  int          b_ctr   [NENT];

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(NENT));
  endfunction

  function automatic logic [31:0] btag(input logic [31:0] pc);
    return pc / 32'(4 * NENT);
  endfunction

  task automatic model_step();
    int ix;
    bit hit, req_now;
    if (rst_i) begin
      m_pc = BOOT; m_shown = 0; m_stale = 0;
      e_instr = 0; e_pc = 0; e_pred = 0;
      e_hit = 0; e_taken = 0; e_mis = 0; e_fault = 0;
      for (int i = 0; i < NENT; i++) b_valid[i] = 0;
      return;
    end
    req_now = !m_shown && !m_stale && ((m_pc % 4) == 0);
    if (redirect_i) begin
      m_stale = (m_stale || req_now) && !u_if.imem_valid_i;
      m_pc = redirect_pc_i;
      m_shown = 0;
    end else if (m_shown) begin
      if (!stall_core_i) begin m_pc = e_pred; m_shown = 0; end
    end else if (m_stale) begin
      if (u_if.imem_valid_i) m_stale = 0;
    end else if ((m_pc % 4) != 0) begin
      e_instr = 32'h0000_0013; e_pc = m_pc; e_pred = m_pc + 32'd4;
      e_hit = 0; e_taken = 0; e_mis = 1; e_fault = 0; m_shown = 1;
    end else if (u_if.imem_valid_i) begin
      ix = bidx(m_pc);
      hit = b_valid[ix] && (b_tag[ix] == btag(m_pc));
      e_hit = hit;
      e_taken = hit && (b_ctr[ix] >= 2);
      e_pred = e_taken ? b_tgt[ix] : m_pc + 32'd4;
      e_instr = u_if.imem_fault_i ? 32'h0000_0013 : u_if.imem_data_i;
      e_pc = m_pc; e_mis = 0; e_fault = u_if.imem_fault_i; m_shown = 1;
    end
    if (bp_upd_i) begin
      ix = bidx(bp_upd_pc_i);
      if (b_valid[ix] && b_tag[ix] == btag(bp_upd_pc_i)) begin
        if (bp_upd_taken_i) b_ctr[ix] = (b_ctr[ix] < 3) ? b_ctr[ix] + 1 : 3;
        else                b_ctr[ix] = (b_ctr[ix] > 0) ? b_ctr[ix] - 1 : 0;
      end else if (bp_upd_taken_i) begin
        b_valid[ix] = 1; b_tag[ix] = btag(bp_upd_pc_i);
        b_tgt[ix] = bp_upd_target_i; b_ctr[ix] = 2;
      end
    end
  endtask

  // Instruction memory: accepts one request, answers after a latency, even if the request is withdrawn
  bit          mem_out;
  int          mem_lat, mem_fix_lat, mem_fault_mode;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic mem_drive();
    u_if.imem_valid_i = 0; u_if.imem_data_i = 0; u_if.imem_fault_i = 0;
    if (rst_i) begin mem_out = 0; return; end
    if (!mem_out && u_if.imem_req_o) begin
      mem_out = 1; mem_addr = u_if.imem_addr_o;
      mem_lat = (mem_fix_lat < 0) ? int'($urandom_range(0, 3)) : mem_fix_lat;
    end
    if (mem_out) begin
      if (mem_lat == 0) begin
        u_if.imem_valid_i = 1;
        u_if.imem_data_i  = mem_data(mem_addr);
        u_if.imem_fault_i = (mem_fault_mode == 1) ||
                            (mem_fault_mode == 2 && $urandom_range(0, 7) == 0);
        mem_out = 0;
      end else begin
        mem_lat--;
      end
    end
  endtask

  task automatic tick();
    #1;
    mem_drive();
    @(posedge clk);
    model_step();
    #1;
    redirect_i = 0;
    bp_upd_i = 0;
  endtask

  task automatic wait_shown(input string name);
    int k = 0;
    while (stall_fetch_o && k < 20) begin tick(); k++; end
    chk({name, "_timeout"}, 32'(stall_fetch_o), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i = 1; redirect_pc_i = pc; tick();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    bp_upd_i = 1; bp_upd_pc_i = pc; bp_upd_target_i = tgt; bp_upd_taken_i = taken; tick();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit exp_req = !rst_i && !m_shown && !m_stale && ((m_pc % 4) == 0);
      chk("stall_fetch", 32'(stall_fetch_o), 32'(!m_shown));
      chk("imem_req", 32'(u_if.imem_req_o), 32'(exp_req));
      if (exp_req) chk("imem_addr", u_if.imem_addr_o, m_pc);
      chk("instr", fetch_instr_o, e_instr);
      chk("pc", fetch_pc_o, e_pc);
      chk("pred_pc", fetch_pred_pc_o, e_pred);
      chk("prediction", 32'(fetch_prediction_o), 32'(e_hit));
      chk("taken", 32'(fetch_taken_o), 32'(e_taken));
      chk("misaligned", 32'(fetch_misaligned_instr_exc_o), 32'(e_mis));
      chk("fault", 32'(fetch_instr_fault_exc_o), 32'(e_fault));
    end
  end

  initial begin
    rst_i = 1; stall_core_i = 1; redirect_i = 0; redirect_pc_i = 0;
    bp_upd_i = 0; bp_upd_pc_i = 0; bp_upd_target_i = 0; bp_upd_taken_i = 0;
    u_if.imem_valid_i = 0; u_if.imem_data_i = 0; u_if.imem_fault_i = 0;
    mem_out = 0; mem_lat = 0; mem_addr = 0; mem_fix_lat = 1; mem_fault_mode = 0;
    m_pc = BOOT; m_shown = 0; m_stale = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_stall", 32'(stall_fetch_o), 32'd1);
    chk("rst_req", 32'(u_if.imem_req_o), 32'd0);
    chk("rst_instr", fetch_instr_o, 32'd0);
    chk("rst_pc", fetch_pc_o, 32'd0);
    rst_i = 0;

    wait_shown("boot");
    chk("boot_pc", fetch_pc_o, 32'h0000_1000);
    chk("boot_instr", fetch_instr_o, 32'hDEAD_BEEF);
    chk("boot_pred", fetch_pred_pc_o, 32'h0000_1004);

    repeat (5) tick();
    chk("hold_pc", fetch_pc_o, 32'h0000_1000);
    chk("hold_req", 32'(u_if.imem_req_o), 32'd0);
    stall_core_i = 0; tick(); stall_core_i = 1;
    chk("next_req", 32'(u_if.imem_req_o), 32'd1);
    chk("next_addr", u_if.imem_addr_o, 32'h0000_1004);

    do_update(32'h0000_1000, 32'h0000_3000, 1);
    do_redirect(32'h0000_1000);
    wait_shown("btb_hit");
    chk("btb_pred", 32'(fetch_prediction_o), 32'd1);
    chk("btb_taken", 32'(fetch_taken_o), 32'd1);
    chk("btb_target", fetch_pred_pc_o, 32'h0000_3000);
    repeat (3) do_update(32'h0000_1000, 32'h0000_3000, 0);
    do_redirect(32'h0000_1000);
    wait_shown("btb_nt");
    chk("btb_nt_pred", 32'(fetch_prediction_o), 32'd1);
    chk("btb_nt_taken", 32'(fetch_taken_o), 32'd0);
    chk("btb_nt_target", fetch_pred_pc_o, 32'h0000_1004);
    do_update(32'h0000_1000, 32'h0000_3000, 1);
    do_redirect(32'h0000_1000);
    wait_shown("btb_floor");
    chk("btb_floor_taken", 32'(fetch_taken_o), 32'd0);

    do_redirect(32'h0000_2002);
    chk("mis_noreq", 32'(u_if.imem_req_o), 32'd0);
    tick();
    chk("mis_exc", 32'(fetch_misaligned_instr_exc_o), 32'd1);
    chk("mis_instr", fetch_instr_o, 32'h0000_0013);
    chk("mis_pc", fetch_pc_o, 32'h0000_2002);

    do_redirect(32'h0000_4000);
    mem_fix_lat = 3;
    tick();
    do_redirect(32'h0000_5000);
    chk("drop_noreq1", 32'(u_if.imem_req_o), 32'd0);
    tick();
    chk("drop_noreq2", 32'(u_if.imem_req_o), 32'd0);
    tick();
    chk("drop_req", 32'(u_if.imem_req_o), 32'd1);
    chk("drop_addr", u_if.imem_addr_o, 32'h0000_5000);
    mem_fix_lat = 1;
    wait_shown("after_drop");
    chk("after_drop_pc", fetch_pc_o, 32'h0000_5000);

    mem_fault_mode = 1;
    stall_core_i = 0; tick(); stall_core_i = 1;
    wait_shown("fault");
    chk("fault_exc", 32'(fetch_instr_fault_exc_o), 32'd1);
    chk("fault_instr", fetch_instr_o, 32'h0000_0013);
    chk("fault_pc", fetch_pc_o, 32'h0000_5004);
    mem_fault_mode = 0;

    do_redirect(32'hFFFF_FFFC);
    wait_shown("wrap");
    chk("wrap_pred", fetch_pred_pc_o, 32'h0000_0000);

    mem_fix_lat = 3;
    stall_core_i = 0; tick(); stall_core_i = 1;
    tick();
    rst_i = 1; tick(); rst_i = 0;
    #1;
    chk("rst_mid_req", 32'(u_if.imem_req_o), 32'd1);
    chk("rst_mid_addr", u_if.imem_addr_o, 32'h0000_1000);

    mem_fix_lat = -1;
    mem_fault_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      stall_core_i = ($urandom_range(0, 2) == 0);
      redirect_i = ($urandom_range(0, 15) == 0);
      redirect_pc_i = 32'h0000_1000 + 32'(4 * $urandom_range(0, 23))
                      + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      bp_upd_i = ($urandom_range(0, 3) == 0);
      bp_upd_pc_i = 32'h0000_1000 + 32'(4 * $urandom_range(0, 23));
      bp_upd_target_i = 32'h0000_1000 + 32'(4 * $urandom_range(0, 23));
      bp_upd_taken_i = $urandom_range(0, 1) == 1;
      tick();
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
